spike_monitor: RTL and testbench

Downstream stage of the LIF neuron. It samples the neuron's spike output every cycle, counts spikes over a programmable window and tracks the minimum inter-spike interval (ISI) in that window. Each closed window produces one result, delivered on a valid/ready interface to the readout/STDP logic. Counting never stalls; results not consumed in time are dropped and flagged.

---
 rtl/spike_monitor_pkg.sv | 31 +++
 rtl/spike_monitor_if.sv | 28 ++
 rtl/spike_isi_tracker.sv | 62 ++++++
 rtl/spike_monitor.sv | 136 +++++++++++++
 tb/tb_spike_monitor.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spike_monitor_pkg.sv
// Shared definitions for the spiking-neuron datapath: controller states and
// saturating counter helpers used by neuron-side counters.
package spike_monitor_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int unsigned DEF_WIN_W = 32'd8;
    localparam int unsigned DEF_CNT_W = 32'd8;
    localparam int unsigned DEF_ISI_W = 32'd8;

    // Largest value representable in a w-bit counter (w up to 32).
    function automatic logic [31:0] max_val(input int unsigned w);
        if (w >= 32'd32) begin
            return 32'hFFFF_FFFF;
        end else begin
            return (32'd1 << w) - 32'd1;
        end
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        if (v >= max_val(w)) begin
            return max_val(w);
        end else begin
            return v + 32'd1;
        end
    endfunction

endpackage

// File: rtl/spike_monitor_if.sv
// Result channel of the spike monitor: valid/ready handshake plus window
// statistics and the sticky drop flag.
interface spike_monitor_if #(
    parameter int CNT_W = 8,
    parameter int ISI_W = 8
);
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] rate;
    logic [ISI_W-1:0] isi_min;
    logic             dropped;

    modport master (
        output out_valid,
        output rate,
        output isi_min,
        output dropped,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  rate,
        input  isi_min,
        input  dropped,
        output out_ready
    );
endinterface

// File: rtl/spike_isi_tracker.sv
// Inter-spike interval tracker: cycles since the last spike, whether a spike
// has been seen, and the running minimum ISI of the current window.
module spike_isi_tracker
    import spike_monitor_pkg::*;
#(
    parameter int ISI_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    input  logic             win_restart,
    input  logic             spike,
    output logic [ISI_W-1:0] min_upd
);
    localparam logic [ISI_W-1:0] ISI_ONES = {ISI_W{1'b1}};

    logic [ISI_W-1:0] isi_cnt_r;
    logic [ISI_W-1:0] isi_min_acc_r;
    logic             have_prev_r;
    logic [31:0]      inc_wide_s;
    logic [ISI_W-1:0] cand_s;
    logic [ISI_W-1:0] min_upd_s;

    // The same saturated increment is both the idle count and the ISI candidate.
    assign inc_wide_s = sat_inc(32'(isi_cnt_r), ISI_W);
    assign cand_s     = inc_wide_s[ISI_W-1:0];

    // Minimum including the current cycle's spike, if it closes an interval.
    always_comb begin
        min_upd_s = isi_min_acc_r;
        if (spike && have_prev_r && (cand_s < isi_min_acc_r)) begin
            min_upd_s = cand_s;
        end else begin
            min_upd_s = isi_min_acc_r;
        end
    end

    assign min_upd = min_upd_s;

    // ISI history survives window boundaries; only the minimum restarts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            isi_cnt_r     <= {ISI_W{1'b0}};
            isi_min_acc_r <= ISI_ONES;
            have_prev_r   <= 1'b0;
        end else if (clear) begin
            isi_cnt_r     <= {ISI_W{1'b0}};
            isi_min_acc_r <= ISI_ONES;
            have_prev_r   <= 1'b0;
        end else if (advance) begin
            isi_cnt_r     <= spike ? {ISI_W{1'b0}} : cand_s;
            have_prev_r   <= have_prev_r | spike;
            isi_min_acc_r <= win_restart ? ISI_ONES : min_upd_s;
        end else begin
            isi_cnt_r     <= isi_cnt_r;
            isi_min_acc_r <= isi_min_acc_r;
            have_prev_r   <= have_prev_r;
        end
    end

endmodule

// File: rtl/spike_monitor.sv
// Windowed spike-rate and minimum-ISI monitor; each closed window yields one
// result on a valid/ready channel, with late results dropped and flagged.
module spike_monitor
    import spike_monitor_pkg::*;
#(
    parameter int WIN_W = 8,
    parameter int CNT_W = 8,
    parameter int ISI_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  spike,
    input  logic [WIN_W-1:0]      win_len,
    spike_monitor_if.master       res
);
    state_t           state_r;
    logic [WIN_W-1:0] len_q_r;
    logic [WIN_W-1:0] win_cnt_r;
    logic [CNT_W-1:0] spike_cnt_r;
    logic             out_valid_r;
    logic [CNT_W-1:0] rate_r;
    logic [ISI_W-1:0] isi_min_r;
    logic             dropped_r;

    logic [WIN_W-1:0] len_eff_s;
    logic [31:0]      cnt_inc_wide_s;
    logic [CNT_W-1:0] cnt_upd_s;
    logic [ISI_W-1:0] min_upd_s;
    logic             run_s;
    logic             clear_s;
    logic             win_end_s;
    logic             xfer_s;
    logic             load_s;
    logic             drop_s;

    assign len_eff_s      = (win_len == {WIN_W{1'b0}}) ? WIN_W'(1) : win_len;
    assign run_s          = (state_r == ST_RUN) && enable;
    assign clear_s        = (state_r == ST_RUN) && !enable;
    assign win_end_s      = run_s && (win_cnt_r == (len_q_r - WIN_W'(1)));
    assign cnt_inc_wide_s = sat_inc(32'(spike_cnt_r), CNT_W);
    assign cnt_upd_s      = spike ? cnt_inc_wide_s[CNT_W-1:0] : spike_cnt_r;

    // A closing window only lands in the output register if the slot is free
    // or is being emptied on this very edge.
    assign xfer_s = out_valid_r & res.out_ready;
    assign load_s = win_end_s & (~out_valid_r | xfer_s);
    assign drop_s = win_end_s & out_valid_r & ~xfer_s;

    spike_isi_tracker #(
        .ISI_W(ISI_W)
    ) u_isi (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear_s),
        .advance    (run_s),
        .win_restart(win_end_s),
        .spike      (spike),
        .min_upd    (min_upd_s)
    );

    // Window controller: state, latched length, cycle counter, spike count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            len_q_r     <= WIN_W'(1);
            win_cnt_r   <= {WIN_W{1'b0}};
            spike_cnt_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    win_cnt_r   <= {WIN_W{1'b0}};
                    spike_cnt_r <= {CNT_W{1'b0}};
                    if (enable) begin
                        state_r <= ST_RUN;
                        len_q_r <= len_eff_s;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        state_r     <= ST_IDLE;
                        win_cnt_r   <= {WIN_W{1'b0}};
                        spike_cnt_r <= {CNT_W{1'b0}};
                    end else if (win_end_s) begin
                        win_cnt_r   <= {WIN_W{1'b0}};
                        spike_cnt_r <= {CNT_W{1'b0}};
                        len_q_r     <= len_eff_s;
                    end else begin
                        win_cnt_r   <= win_cnt_r + WIN_W'(1);
                        spike_cnt_r <= cnt_upd_s;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    win_cnt_r   <= {WIN_W{1'b0}};
                    spike_cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Output holding register and sticky drop flag; set beats clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            rate_r      <= {CNT_W{1'b0}};
            isi_min_r   <= {ISI_W{1'b1}};
            dropped_r   <= 1'b0;
        end else begin
            if (load_s) begin
                out_valid_r <= 1'b1;
                rate_r      <= cnt_upd_s;
                isi_min_r   <= min_upd_s;
            end else if (xfer_s) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
            if (drop_s) begin
                dropped_r <= 1'b1;
            end else if (xfer_s) begin
                dropped_r <= 1'b0;
            end else begin
                dropped_r <= dropped_r;
            end
        end
    end

    assign res.out_valid = out_valid_r;
    assign res.rate      = rate_r;
    assign res.isi_min   = isi_min_r;
    assign res.dropped   = dropped_r;

endmodule

// File: tb/tb_spike_monitor.sv
// Randomized scoreboard bench for spike_monitor; the reference model works
// from spike timestamps per window rather than cycle counters.
module tb_spike_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       spike;
    logic [7:0] win_len;

    spike_monitor_if #(.CNT_W(8), .ISI_W(8)) bus ();

    spike_monitor #(.WIN_W(8), .CNT_W(8), .ISI_W(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .spike  (spike),
        .win_len(win_len),
        .res    (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int cyc;
    bit m_run;
    int m_len;
    int m_pos;
    int win_sp[$];
    bit pre_v;
    int pre_t;
    bit m_valid;
    bit m_drop;
    int exp_q[$];
    int pushes;
    int pops;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        cyc     = 0;
        m_run   = 1'b0;
        m_len   = 1;
        m_pos   = 0;
        win_sp.delete();
        pre_v   = 1'b0;
        pre_t   = 0;
        m_valid = 1'b0;
        m_drop  = 1'b0;
        exp_q.delete();
    endtask

    // One clock edge of the behavioural model, using inputs as seen at the edge.
    task automatic model_step();
        bit res_now;
        bit xfer;
        bit drop_now;
        int r_cnt;
        int r_min;
        int d;
        res_now = 1'b0;
        r_cnt   = 0;
        r_min   = 255;
        cyc++;
        xfer = m_valid && bus.out_ready;
        if (m_run) begin
            if (!enable) begin
                m_run = 1'b0;
                win_sp.delete();
                pre_v = 1'b0;
            end else begin
                if (spike) win_sp.push_back(cyc);
                m_pos++;
                if (m_pos == m_len) begin
                    r_cnt = (win_sp.size() > 255) ? 255 : win_sp.size();
                    foreach (win_sp[i]) begin
                        if (pre_v) begin
                            d = win_sp[i] - pre_t;
                            if (d > 255) d = 255;
                            if (d < r_min) r_min = d;
                        end
                        pre_v = 1'b1;
                        pre_t = win_sp[i];
                    end
                    win_sp.delete();
                    res_now = 1'b1;
                    m_pos   = 0;
                    m_len   = (win_len == 8'd0) ? 1 : int'(win_len);
                end
            end
        end else if (enable) begin
            m_run = 1'b1;
            m_len = (win_len == 8'd0) ? 1 : int'(win_len);
            m_pos = 0;
        end
        drop_now = res_now && m_valid && !xfer;
        if (res_now && (!m_valid || xfer)) begin
            m_valid = 1'b1;
            exp_q.push_back(r_cnt * 256 + r_min);
            pushes++;
        end else if (xfer) begin
            m_valid = 1'b0;
        end
        if (drop_now) m_drop = 1'b1;
        else if (xfer) m_drop = 1'b0;
    endtask

    initial begin
        pushes = 0;
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    // Monitor: handshake state every cycle, result payload on each transfer.
    initial begin
        int e;
        pops = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("out_valid", int'(bus.out_valid), int'(m_valid));
                check("dropped", int'(bus.dropped), int'(m_drop));
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        pops++;
                        check("rate", int'(bus.rate), e / 256);
                        check("isi_min", int'(bus.isi_min), e % 256);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, int'(bus.out_valid), 0);
        check({tag, "_rate"}, int'(bus.rate), 0);
        check({tag, "_isi"}, int'(bus.isi_min), 255);
        check({tag, "_dropped"}, int'(bus.dropped), 0);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; spike = 1'b0; win_len = 8'd4; bus.out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check_reset_outputs("reset");

        // Basic window: length 8, spikes at offsets 1,3,7.
        enable = 1'b1; win_len = 8'd8; bus.out_ready = 1'b1;
        tick();
        for (int i = 0; i < 24; i++) begin
            spike = ((i % 8) == 1) || ((i % 8) == 3) || ((i % 8) == 7);
            tick();
        end
        spike = 1'b0;

        // Single spike per window, then spacing across a boundary.
        enable = 1'b0; tick(); enable = 1'b1; win_len = 8'd5; tick();
        for (int i = 0; i < 15; i++) begin
            spike = (i == 2) || (i == 5) || (i == 13);
            tick();
        end
        spike = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 15) == 0) win_len = 8'($urandom_range(0, 9));
            spike         = ($urandom_range(0, 99) < 30);
            bus.out_ready = ($urandom_range(0, 99) < 60);
            enable        = ($urandom_range(0, 99) < 97);
            tick();
        end

        // Saturation: length-0 windows with constant spiking, then 255-cycle windows.
        enable = 1'b1; win_len = 8'd0; spike = 1'b1;
        for (int i = 0; i < 320; i++) begin
            bus.out_ready = ($urandom_range(0, 1) == 1);
            tick();
        end
        win_len = 8'd255; bus.out_ready = 1'b1;
        repeat (560) tick();
        spike = 1'b0;

        // Backpressure: stall across several windows, then release.
        enable = 1'b0; tick();
        enable = 1'b1; win_len = 8'd4; bus.out_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            spike = ($urandom_range(0, 1) == 1);
            tick();
        end
        bus.out_ready = 1'b1;
        repeat (10) tick();

        // Enable drop mid-window, then a fresh window.
        enable = 1'b0; tick();
        enable = 1'b1; win_len = 8'd6; tick();
        spike = 1'b1; tick(); spike = 1'b0; tick();
        enable = 1'b0; tick();
        enable = 1'b1; tick();
        for (int i = 0; i < 12; i++) begin
            spike = (i == 1) || (i == 4);
            tick();
        end
        spike = 1'b0;

        // Asynchronous reset mid-window with a pending result.
        win_len = 8'd4; bus.out_ready = 1'b0; spike = 1'b1;
        repeat (6) tick();
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        repeat (20) tick();

        // Drain and confirm every expected result was delivered.
        enable = 1'b0; spike = 1'b0;
        repeat (10) tick();
        check("drain_queue_empty", exp_q.size(), 0);
        check("results_delivered", int'(pops > 100), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
